mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles in BUSY without mem_ack before abort (8-bit range, 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port mem_rd_req, input, 1: CPU read request, held until accepted.
REQ-005 SHALL have port mem_wr_req, input, 1: CPU write request, held until accepted.
REQ-006 SHALL have port pma, input, 22: physical word address.
REQ-007 SHALL have port md, input, 32: write data from the memory data register.
REQ-008 SHALL have port srcmd, input, 1: CPU is sourcing MD this cycle.
REQ-009 SHALL have port mem_req, output, 1: bus cycle request.
REQ-010 SHALL have port mem_write, output, 1: bus cycle is a write.
REQ-011 SHALL have port mem_addr, output, 22: latched address.
REQ-012 SHALL have port mem_wdata, output, 32: latched write data.
REQ-013 SHALL have port mem_ack, input, 1: bus cycle complete; mem_rdata is valid for reads.
REQ-014 SHALL have port mem_rdata, input, 32: bus read data.
REQ-015 SHALL have port mds, output, 32: registered read data to the MD register.
REQ-016 SHALL have port loadmd, output, 1: one-cycle MD load strobe.
REQ-017 SHALL have port memrq, output, 1: a read cycle is outstanding or completing.
REQ-018 SHALL have port memwait, output, 1: CPU stall.
REQ-019 SHALL have port mem_timeout, output, 1: sticky abort flag.

Function
REQ-020 SHALL implement states IDLE, BUSY and LOAD.
REQ-021 IDLE: on mem_wr_req or mem_rd_req, SHALL latch pma into mem_addr and set mem_write = mem_wr_req. A write SHALL also latch md into mem_wdata. SHALL then go to BUSY.
REQ-022 If mem_wr_req and mem_rd_req are both high in IDLE, the write SHALL be accepted. The read stays pending and is accepted when IDLE is next reached.
REQ-023 mem_req SHALL be 1 exactly while in BUSY. mem_addr, mem_write and mem_wdata SHALL stay stable throughout BUSY.
REQ-024 BUSY with mem_ack on a read: SHALL capture mem_rdata into mds and go to LOAD.
REQ-025 BUSY with mem_ack on a write: SHALL go to IDLE; mds is unchanged.
REQ-026 LOAD: loadmd SHALL be 1 for exactly that one cycle, then the state SHALL go to IDLE.
REQ-027 mds SHALL hold its value until the next read capture.
REQ-028 memrq SHALL be 1 in BUSY and LOAD for reads, and 0 otherwise.
REQ-029 memwait SHALL be 1 when state is not IDLE and any of these is true: mem_rd_req, mem_wr_req, or (srcmd and a read is in BUSY).
REQ-030 memwait SHALL be 0 in LOAD for srcmd alone.
REQ-031 mem_ack SHALL be ignored in IDLE and LOAD.
REQ-032 Requests arriving outside IDLE SHALL NOT be accepted.
REQ-033 Latency: request accepted at edge N → mem_req from N+1. mem_ack sampled at edge M → loadmd during cycle M+1. Minimum request-to-loadmd is 2 cycles.
REQ-034 Back-to-back: a request held high during LOAD or write completion SHALL be accepted in the following IDLE cycle.

Reset
REQ-035 reset low SHALL immediately force state IDLE and all outputs to 0: mem_req, mem_write, mem_addr, mem_wdata, mds, loadmd, memrq, memwait, mem_timeout.
REQ-036 Reset asserted mid-BUSY SHALL drop mem_req without waiting for mem_ack. A late mem_ack after reset release SHALL be ignored.

Configuration
REQ-037 Macro MEM_SEQ_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-038 When that counter reaches TIMEOUT_CYCLES, the block SHALL:
- leave BUSY (mem_req drops);
- set mem_timeout;
- on a read, load mds with 32'hFFFFFFFF and take LOAD;
- on a write, go to IDLE.
REQ-039 mem_timeout SHALL stay set until the next accepted request.
REQ-040 Macro MEM_SEQ_TIMEOUT_EN undefined: BUSY SHALL wait indefinitely, mem_timeout SHALL be constant 0, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-041 Read: pma=22'h001234 with mem_rd_req; mem_ack with mem_rdata=32'hDEADBEEF on the 3rd BUSY cycle → mem_addr=22'h001234 and mem_req high 3 cycles; mds=32'hDEADBEEF with loadmd=memrq=1 for one cycle, then IDLE.
REQ-042 Write: md=32'h0000CAFE with mem_wr_req, held 2 cycles → mem_write=1 and mem_wdata=32'h0000CAFE; second request stalled (memwait=1) until IDLE; loadmd never pulses; mds unchanged.
REQ-043 mem_rd_req and mem_wr_req raised together → write bus cycle first, then read bus cycle; loadmd pulses once, after the read.
REQ-044 Reset low during BUSY, with mem_ack arriving 2 cycles after release → mem_req 0 immediately; all outputs 0; mds stays 0.
REQ-045 With MEM_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no mem_ack → mem_req high 4 cycles; then loadmd=1 and mds=32'hFFFFFFFF; mem_timeout=1 until next request.

Source files
------------

// File: rtl/mem_seq.sv
// Memory bus sequencer: turns held CPU read/write requests into single bus cycles and returns read data to MD.
// Optional BUSY watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_seq #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd_req,
   input  logic        mem_wr_req,
   input  logic [21:0] pma,
   input  logic [31:0] md,
   input  logic        srcmd,
   output logic        mem_req,
   output logic        mem_write,
   output logic [21:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mds,
   output logic        loadmd,
   output logic        memrq,
   output logic        memwait,
   output logic        mem_timeout,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   timeout_hit;

   // Handshake: a CPU request is a level held until accepted; acceptance happens only on a
   // clock edge in IDLE (write wins). The bus side holds mem_req until the edge that samples mem_ack.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_wr_req || mem_rd_req) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack || timeout_hit)
               state_nxt = mem_write ? IDLE : LOAD;
         end
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mds       <= '0;
      end else begin
         if (accept) begin
            mem_addr  <= pma;
            mem_write <= mem_wr_req;
            if (mem_wr_req) mem_wdata <= md;
         end
         if (state == BUSY && !mem_write) begin
            if (mem_ack)          mds <= mem_rdata;
            else if (timeout_hit) mds <= 32'hFFFF_FFFF;
         end
      end
   end

`ifdef MEM_SEQ_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] to_cnt;
   logic       to_flag;

   // Abort on the edge that would otherwise start BUSY cycle TIMEOUT_CYCLES+1; a coincident ack wins.
   assign timeout_hit = (state == BUSY) && !mem_ack && (to_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else begin
         if (accept)
            to_cnt <= '0;
         else if (state == BUSY && !mem_ack)
            to_cnt <= to_cnt + 8'd1;
         if (accept)           to_flag <= 1'b0;
         else if (timeout_hit) to_flag <= 1'b1;
      end
   end

   assign mem_timeout = to_flag;
`else
   assign timeout_hit = 1'b0;
   assign mem_timeout = 1'b0;
`endif

   assign mem_req   = (state == BUSY);
   assign loadmd    = (state == LOAD);
   assign memrq     = (state == BUSY || state == LOAD) && !mem_write;
   assign memwait   = (state != IDLE) &&
                      (mem_rd_req || mem_wr_req || (srcmd && state == BUSY && !mem_write));
   assign state_dbg = state;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: vector table for the single-cycle behaviour plus hand sequences
// for reset mid-cycle and the BUSY watchdog (or its absence).
module tb_mem_seq;

   logic        clk;
   logic        reset;
   logic        mem_rd_req, mem_wr_req;
   logic [21:0] pma;
   logic [31:0] md;
   logic        srcmd;
   logic        mem_req, mem_write;
   logic [21:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] mds;
   logic        loadmd, memrq, memwait, mem_timeout;
   logic [1:0]  state_dbg;

   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_LOAD = 2'd2;

   int checks = 0;
   int errors = 0;

   mem_seq #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .pma(pma), .md(md), .srcmd(srcmd),
      .mem_req(mem_req), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mds(mds), .loadmd(loadmd), .memrq(memrq), .memwait(memwait),
      .mem_timeout(mem_timeout), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [93:0] dut_vec;
   assign dut_vec = {mem_req, mem_write, mem_addr, mem_wdata, mds,
                     loadmd, memrq, memwait, mem_timeout, state_dbg};

   function automatic logic [93:0] pk(input logic req, input logic wr, input logic [21:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rd_data,
                                      input logic ld, input logic rq, input logic wt,
                                      input logic to, input logic [1:0] st);
      return {req, wr, addr, wdata, rd_data, ld, rq, wt, to, st};
   endfunction

   typedef struct {
      logic        rd;
      logic        wr;
      logic [21:0] pma;
      logic [31:0] md;
      logic        srcmd;
      logic        ack;
      logic [31:0] rdata;
      logic [93:0] exp;
   } vec_t;

   vec_t vec_q[$];

   task automatic add(input logic rd, input logic wr, input logic [21:0] a, input logic [31:0] d,
                      input logic s, input logic k, input logic [31:0] r, input logic [93:0] e);
      vec_t v;
      v.rd = rd; v.wr = wr; v.pma = a; v.md = d; v.srcmd = s; v.ack = k; v.rdata = r; v.exp = e;
      vec_q.push_back(v);
   endtask

   // driver tasks
   task automatic drive(input logic rd, input logic wr, input logic [21:0] a, input logic [31:0] d,
                        input logic s, input logic k, input logic [31:0] r);
      mem_rd_req = rd; mem_wr_req = wr; pma = a; md = d; srcmd = s; mem_ack = k; mem_rdata = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard
   task automatic chk(input string name, input logic [93:0] exp);
      checks++;
      if (dut_vec !== exp) begin
         errors++;
         $display("FAIL %s: got %h exp %h", name, dut_vec, exp);
      end
   endtask

   initial begin
      // read: ack on the third BUSY cycle, srcmd stall only while the read is in BUSY
      add(1,0,22'h001234,0,0,0,0,           pk(1,0,22'h001234,0,0,            0,1,1,0,S_BUSY));
      add(0,0,22'h001234,0,0,0,0,           pk(1,0,22'h001234,0,0,            0,1,0,0,S_BUSY));
      add(0,0,22'h001234,0,1,0,0,           pk(1,0,22'h001234,0,0,            0,1,1,0,S_BUSY));
      add(0,0,22'h001234,0,1,1,32'hDEADBEEF,pk(0,0,22'h001234,0,32'hDEADBEEF, 1,1,0,0,S_LOAD));
      add(0,0,22'h001234,0,0,1,32'h11111111,pk(0,0,22'h001234,0,32'hDEADBEEF, 0,0,0,0,S_IDLE));
      add(0,0,22'h001234,0,0,1,32'h11111111,pk(0,0,22'h001234,0,32'hDEADBEEF, 0,0,0,0,S_IDLE));
      // write held two cycles; request seen in BUSY must not relatch
      add(0,1,22'h000ABC,32'h0000CAFE,0,0,0,pk(1,1,22'h000ABC,32'h0000CAFE,32'hDEADBEEF,0,0,1,0,S_BUSY));
      add(0,1,22'h0000FF,32'h00001234,0,0,0,pk(1,1,22'h000ABC,32'h0000CAFE,32'hDEADBEEF,0,0,1,0,S_BUSY));
      add(0,0,22'h0000FF,32'h00001234,0,1,0,pk(0,1,22'h000ABC,32'h0000CAFE,32'hDEADBEEF,0,0,0,0,S_IDLE));
      // back-to-back writes, srcmd during a write does not stall
      add(0,1,22'h3FFFFF,32'h55,0,0,0,      pk(1,1,22'h3FFFFF,32'h55,32'hDEADBEEF,0,0,1,0,S_BUSY));
      add(0,1,22'h3FFFFF,32'h55,0,1,0,      pk(0,1,22'h3FFFFF,32'h55,32'hDEADBEEF,0,0,0,0,S_IDLE));
      add(0,1,22'h000001,32'h66,1,0,0,      pk(1,1,22'h000001,32'h66,32'hDEADBEEF,0,0,1,0,S_BUSY));
      add(0,0,22'h000001,32'h66,1,0,0,      pk(1,1,22'h000001,32'h66,32'hDEADBEEF,0,0,0,0,S_BUSY));
      add(0,0,22'h000001,32'h66,1,1,0,      pk(0,1,22'h000001,32'h66,32'hDEADBEEF,0,0,0,0,S_IDLE));
      // read and write together: write first, then the pending read
      add(1,1,22'h002222,32'hAAAA5555,0,0,0,pk(1,1,22'h002222,32'hAAAA5555,32'hDEADBEEF,0,0,1,0,S_BUSY));
      add(1,0,22'h002222,32'hAAAA5555,0,1,0,pk(0,1,22'h002222,32'hAAAA5555,32'hDEADBEEF,0,0,0,0,S_IDLE));
      add(1,0,22'h002222,0,0,0,0,           pk(1,0,22'h002222,32'hAAAA5555,32'hDEADBEEF,0,1,1,0,S_BUSY));
      add(1,0,22'h002222,0,0,1,32'h0BADF00D,pk(0,0,22'h002222,32'hAAAA5555,32'h0BADF00D,1,1,1,0,S_LOAD));
      // read held through LOAD is taken in the next IDLE
      add(1,0,22'h003333,0,0,0,0,           pk(0,0,22'h002222,32'hAAAA5555,32'h0BADF00D,0,0,0,0,S_IDLE));
      add(1,0,22'h003333,0,0,0,0,           pk(1,0,22'h003333,32'hAAAA5555,32'h0BADF00D,0,1,1,0,S_BUSY));
      add(0,0,22'h003333,0,1,1,32'h12345678,pk(0,0,22'h003333,32'hAAAA5555,32'h12345678,1,1,0,0,S_LOAD));
      add(0,0,22'h003333,0,0,0,0,           pk(0,0,22'h003333,32'hAAAA5555,32'h12345678,0,0,0,0,S_IDLE));

      reset = 1'b0;
      drive(0,0,0,0,0,0,0);
      repeat (2) step();
      chk("reset_state", '0);
      #2 reset = 1'b1;
      step();
      chk("post_reset_idle", '0);

      foreach (vec_q[i]) begin
         drive(vec_q[i].rd, vec_q[i].wr, vec_q[i].pma, vec_q[i].md,
               vec_q[i].srcmd, vec_q[i].ack, vec_q[i].rdata);
         step();
         chk($sformatf("vec%0d", i), vec_q[i].exp);
      end

      // reset asserted mid-BUSY, late ack after release
      drive(1,0,22'h000777,0,0,0,0);
      step();
      chk("rst_pre_busy", pk(1,0,22'h000777,32'hAAAA5555,32'h12345678,0,1,1,0,S_BUSY));
      drive(0,0,22'h000777,0,1,0,0);
      #3 reset = 1'b0;
      #1 chk("rst_immediate", '0);
      step();
      chk("rst_held", '0);
      #2 reset = 1'b1;
      step();
      chk("rst_release", '0);
      step();
      drive(0,0,22'h000777,0,0,1,32'hCAFEBABE);
      step();
      chk("rst_late_ack", '0);
      drive(0,0,0,0,0,0,0);
      step();
      chk("rst_after_ack", '0);

`ifdef MEM_SEQ_TIMEOUT_EN
      drive(1,0,22'h000042,0,0,0,0);
      step();
      chk("to_busy1", pk(1,0,22'h000042,0,0,0,1,1,0,S_BUSY));
      drive(0,0,22'h000042,0,0,0,0);
      for (int i = 2; i <= 4; i++) begin
         step();
         chk($sformatf("to_busy%0d", i), pk(1,0,22'h000042,0,0,0,1,0,0,S_BUSY));
      end
      step();
      chk("to_load", pk(0,0,22'h000042,0,32'hFFFFFFFF,1,1,0,1,S_LOAD));
      step();
      chk("to_idle_sticky", pk(0,0,22'h000042,0,32'hFFFFFFFF,0,0,0,1,S_IDLE));
      drive(0,1,22'h000005,32'h7,0,0,0);
      step();
      chk("to_clear", pk(1,1,22'h000005,32'h7,32'hFFFFFFFF,0,0,1,0,S_BUSY));
      drive(0,0,22'h000005,32'h7,0,1,0);
      step();
      chk("to_wr_done", pk(0,1,22'h000005,32'h7,32'hFFFFFFFF,0,0,0,0,S_IDLE));
`else
      drive(1,0,22'h000042,0,0,0,0);
      step();
      chk("wait_busy1", pk(1,0,22'h000042,0,0,0,1,1,0,S_BUSY));
      drive(0,0,22'h000042,0,0,0,0);
      for (int i = 0; i < 300; i++) begin
         step();
         chk($sformatf("wait_busy_c%0d", i), pk(1,0,22'h000042,0,0,0,1,0,0,S_BUSY));
      end
      drive(0,0,22'h000042,0,0,1,32'h00005A5A);
      step();
      chk("wait_load", pk(0,0,22'h000042,0,32'h00005A5A,1,1,0,0,S_LOAD));
      drive(0,0,0,0,0,0,0);
      step();
      chk("wait_idle", pk(0,0,22'h000042,0,32'h00005A5A,0,0,0,0,S_IDLE));
`endif

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
